decode_rf_skid_reg: RTL and testbench

- Elastic pipeline register between the decode stage and the register-fetch stage; replaces the plain enable-gated register with a valid/ready handshake.
- Holds up to two decoded-instruction payloads (main + skid entry), so backpressure from register fetch never forms a combinational path back to decode.
- Supports a pipeline flush for branch/warp kill and counts downstream stall cycles for performance monitoring.

---
 rtl/decode_rf_skid_reg.sv | 101 ++++++++++
 tb/tb_decode_rf_skid_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/decode_rf_skid_reg.sv
// Two-entry elastic register between decode and register fetch.
// in_ready/out_valid come from registered state only, so there is no ready path back to decode.
module decode_rf_skid_reg #(
    parameter int DataWidth = 142,
    parameter int CntWidth  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data,
    output logic [1:0]           occupancy,
    output logic [CntWidth-1:0]  stall_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DataWidth-1:0]  main_q, main_d;
    logic [DataWidth-1:0]  skid_q, skid_d;
    logic [CntWidth-1:0]   stall_q, stall_d;
    logic                  in_fire;
    logic                  out_fire;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // A kill drops everything in flight; data registers keep their contents.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        if (out_valid && !out_ready && (stall_q != {CntWidth{1'b1}})) begin
            stall_d = stall_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_decode_rf_skid_reg.sv
// Bench for decode_rf_skid_reg: hand-computed vector table, then random traffic
// checked against a queue-based model of a two-deep FIFO with a saturating stall counter.
module tb_decode_rf_skid_reg;

    localparam int DW = 142;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    decode_rf_skid_reg #(.DataWidth(DW), .CntWidth(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: held payloads in arrival order, last head value, stall count
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_main;
    int unsigned   m_stall;
    int            tests;
    int            fails;

    typedef struct {
        string         tag;
        logic          rst;
        logic          iv;
        logic [DW-1:0] d;
        logic          fl;
        logic          ordy;
        logic          e_ov;
        logic          e_ir;
        logic [1:0]    e_occ;
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_st;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string where);
        chk({where, " out_valid"}, DW'(out_valid), DW'(exp_q.size() != 0));
        chk({where, " in_ready"},  DW'(in_ready),  DW'(exp_q.size() < 2));
        chk({where, " occupancy"}, DW'(occupancy), DW'(exp_q.size()));
        chk({where, " out_data"},  out_data, (exp_q.size() != 0) ? exp_q[0] : m_main);
        chk({where, " stall_cnt"}, DW'(stall_cnt), DW'(m_stall));
    endtask

    // Advance the model by one rising edge with the given inputs.
    task automatic model_step(input logic r, input logic iv, input logic [DW-1:0] d,
                              input logic fl, input logic ordy);
        bit inf, outf;
        inf  = iv && (exp_q.size() < 2);
        outf = ordy && (exp_q.size() != 0);
        if (exp_q.size() != 0 && !ordy && m_stall < (2**CW - 1)) m_stall++;
        if (r) begin
            exp_q.delete();
            m_main  = '0;
            m_stall = 0;
        end else if (fl) begin
            exp_q.delete();
        end else begin
            if (outf) void'(exp_q.pop_front());
            if (inf) exp_q.push_back(d);
        end
        if (exp_q.size() != 0) m_main = exp_q[0];
    endtask

    // Driver: apply inputs, check mid-cycle (after out_ready changed), clock, check again.
    task automatic drive_cycle(input logic r, input logic iv, input logic [DW-1:0] d,
                               input logic fl, input logic ordy);
        rst = r; in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
        #1;
        chk_model("pre");
        @(posedge clk);
        model_step(r, iv, d, fl, ordy);
        #1;
        chk_model("post");
    endtask

    function automatic void add(input string tag, input logic r, input logic iv,
                                input logic [DW-1:0] d, input logic fl, input logic ordy,
                                input logic ov, input logic ir, input logic [1:0] occ,
                                input logic [DW-1:0] od, input logic [CW-1:0] st);
        vec_t v;
        v.tag = tag; v.rst = r; v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy;
        v.e_ov = ov; v.e_ir = ir; v.e_occ = occ; v.e_od = od; v.e_st = st;
        vecs.push_back(v);
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    initial begin
        tests = 0; fails = 0;
        m_main = '0; m_stall = 0;

        // Expected values are the outputs seen just after that row's clock edge.
        //   tag       rst iv data  fl ordy  ov ir occ od    st
        add("rst0",    1, 1, 'h5A, 0, 0,    0, 1, 0, 'h0,  0);
        add("rst1",    1, 1, 'h5A, 0, 0,    0, 1, 0, 'h0,  0);
        add("str1",    0, 1, 'h1,  0, 1,    1, 1, 1, 'h1,  0);
        add("str2",    0, 1, 'h2,  0, 1,    1, 1, 1, 'h2,  0);
        add("str3",    0, 1, 'h3,  0, 1,    1, 1, 1, 'h3,  0);
        add("str4",    0, 1, 'h4,  0, 1,    1, 1, 1, 'h4,  0);
        add("strdrn",  0, 0, 'h0,  0, 1,    0, 1, 0, 'h4,  0);
        add("bpA",     0, 1, 'hA,  0, 0,    1, 1, 1, 'hA,  0);
        add("bpB",     0, 1, 'hB,  0, 0,    1, 0, 2, 'hA,  1);
        add("bpCheld", 0, 1, 'hC,  0, 0,    1, 0, 2, 'hA,  2);
        add("bpoutA",  0, 1, 'hC,  0, 1,    1, 1, 1, 'hB,  2);
        add("bpoutB",  0, 1, 'hC,  0, 1,    1, 1, 1, 'hC,  2);
        add("bpoutC",  0, 0, 'h0,  0, 1,    0, 1, 0, 'hC,  2);
        add("fl_f1",   0, 1, 'h11, 0, 0,    1, 1, 1, 'h11, 2);
        add("fl_f2",   0, 1, 'h12, 0, 0,    1, 0, 2, 'h11, 3);
        add("flushD",  0, 1, 'hD,  1, 0,    0, 1, 0, 'h11, 3);
        add("fl_E",    0, 1, 'hE,  0, 0,    1, 1, 1, 'hE,  3);
        add("fl_outE", 0, 0, 'h0,  0, 1,    0, 1, 0, 'hE,  3);
        add("st_rst",  1, 0, 'h0,  0, 0,    0, 1, 0, 'h0,  0);
        add("st_ld",   0, 1, 'h21, 0, 0,    1, 1, 1, 'h21, 0);
        add("st1",     0, 0, 'h0,  0, 0,    1, 1, 1, 'h21, 1);
        add("st2",     0, 0, 'h0,  0, 0,    1, 1, 1, 'h21, 2);
        add("st3",     0, 0, 'h0,  0, 0,    1, 1, 1, 'h21, 3);
        add("st4",     0, 0, 'h0,  0, 0,    1, 1, 1, 'h21, 3);
        add("st5",     0, 0, 'h0,  0, 0,    1, 1, 1, 'h21, 3);
        add("st6",     0, 0, 'h0,  0, 0,    1, 1, 1, 'h21, 3);
        add("st_fl",   0, 0, 'h0,  1, 0,    0, 1, 0, 'h21, 3);
        add("st_clr",  1, 0, 'h0,  0, 0,    0, 1, 0, 'h0,  0);

        // Initial reset so the model and DUT start aligned.
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive_cycle(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].fl, vecs[i].ordy);
            chk({vecs[i].tag, " out_valid"}, DW'(out_valid), DW'(vecs[i].e_ov));
            chk({vecs[i].tag, " in_ready"},  DW'(in_ready),  DW'(vecs[i].e_ir));
            chk({vecs[i].tag, " occupancy"}, DW'(occupancy), DW'(vecs[i].e_occ));
            chk({vecs[i].tag, " out_data"},  out_data,       vecs[i].e_od);
            chk({vecs[i].tag, " stall_cnt"}, DW'(stall_cnt), DW'(vecs[i].e_st));
        end

        // Load one entry, then 8 cycles of continuous input with out_ready toggling.
        drive_cycle(0, 1, rand_data(), 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(0, 1, rand_data(), 0, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, '0, 0, 1);
        chk("drain occupancy", DW'(occupancy), DW'(0));

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            drive_cycle(r == 0, $urandom_range(0, 3) != 0, rand_data(),
                        (r >= 1 && r <= 3), $urandom_range(0, 2) != 0);
            if (occupancy > 2) begin
                fails++;
                $display("FAIL occ_bound: got %0d expected <=2", occupancy);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
